// File: rtl/rep_sequencer_if.sv
// Handshake bundle between the decode stage, the REP sequencer and execute.
// The sequencer connects through the slave modport; the environment drives the master side.
interface rep_sequencer_if #(
    parameter int ECX_WIDTH = 32
);
    logic                 up_valid;
    logic                 up_ready;
    logic [1:0]           up_rep_mode;
    logic                 up_addr32;
    logic [ECX_WIDTH-1:0] up_ecx;

    logic                 ex_valid;
    logic                 ex_ready;
    logic                 ex_last;
    logic [ECX_WIDTH-1:0] ex_ecx;

    logic                 fb_valid;
    logic                 fb_zf;

    logic                 seq_done;
    logic [ECX_WIDTH-1:0] done_ecx;
    logic                 busy;

    modport slave (
        input  up_valid, up_rep_mode, up_addr32, up_ecx, ex_ready, fb_valid, fb_zf,
        output up_ready, ex_valid, ex_last, ex_ecx, seq_done, done_ecx, busy
    );

    modport master (
        output up_valid, up_rep_mode, up_addr32, up_ecx, ex_ready, fb_valid, fb_zf,
        input  up_ready, ex_valid, ex_last, ex_ecx, seq_done, done_ecx, busy
    );
endinterface

// File: rtl/rep_sequencer.sv
// REP/REPE/REPNE string-instruction sequencer: issues one iteration per count,
// optionally waiting for ZF feedback between iterations. ECX_WIDTH must exceed 16.
module rep_sequencer #(
    parameter int ECX_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    rep_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FLAG} state_t;

    state_t               state_reg;
    logic [ECX_WIDTH-1:0] count_reg;
    logic [ECX_WIDTH-1:0] ex_ecx_reg;
    logic [ECX_WIDTH-1:0] done_ecx_reg;
    logic [1:0]           mode_reg;
    logic                 addr32_reg;
    logic                 ex_valid_reg;
    logic                 ex_last_reg;
    logic                 seq_done_reg;

    // In 16-bit mode the decrement wraps inside [15:0]; upper bits pass through untouched.
    function automatic logic [ECX_WIDTH-1:0] dec_count(input logic [ECX_WIDTH-1:0] v,
                                                       input logic wide);
        logic [ECX_WIDTH-1:0] r;
        if (wide) begin
            r = v - ECX_WIDTH'(1);
        end else begin
            r = {v[ECX_WIDTH-1:16], v[15:0] - 16'd1};
        end
        return r;
    endfunction

    function automatic logic is_zero(input logic [ECX_WIDTH-1:0] v, input logic wide);
        return wide ? (v == '0) : (v[15:0] == 16'd0);
    endfunction

    logic [ECX_WIDTH-1:0] entry_dec;
    logic [ECX_WIDTH-1:0] count_dec;
    logic [ECX_WIDTH-1:0] next_dec;
    logic                 terminate;
    logic                 issue_valid;

    assign entry_dec = dec_count(bus.up_ecx, bus.up_addr32);
    assign count_dec = dec_count(count_reg, addr32_reg);
    assign next_dec  = dec_count(ex_ecx_reg, addr32_reg);
    assign terminate = bus.fb_zf ? (mode_reg == 2'b11) : (mode_reg == 2'b10);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            ex_valid_reg <= 1'b0;
            seq_done_reg <= 1'b0;
            if (!reset) begin
                mode_reg     <= 2'b00;
                addr32_reg   <= 1'b0;
                ex_last_reg  <= 1'b0;
                ex_ecx_reg   <= '0;
                done_ecx_reg <= '0;
            end
        end else begin
            seq_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.up_valid) begin
                        mode_reg   <= bus.up_rep_mode;
                        addr32_reg <= bus.up_addr32;
                        count_reg  <= bus.up_ecx;
                        if (bus.up_rep_mode == 2'b00) begin
                            state_reg    <= ISSUE;
                            ex_valid_reg <= 1'b1;
                            ex_last_reg  <= 1'b1;
                            ex_ecx_reg   <= bus.up_ecx;
                        end else if (is_zero(bus.up_ecx, bus.up_addr32)) begin
                            seq_done_reg <= 1'b1;
                            done_ecx_reg <= bus.up_ecx;
                        end else begin
                            state_reg    <= ISSUE;
                            ex_valid_reg <= 1'b1;
                            ex_ecx_reg   <= entry_dec;
                            ex_last_reg  <= is_zero(entry_dec, bus.up_addr32);
                        end
                    end
                end
                ISSUE: begin
                    if (bus.ex_ready) begin
                        // ex_ecx_reg already holds the post-decrement count (or the unchanged one for mode 00)
                        count_reg <= ex_ecx_reg;
                        if (ex_last_reg || mode_reg == 2'b00) begin
                            state_reg    <= IDLE;
                            ex_valid_reg <= 1'b0;
                            seq_done_reg <= 1'b1;
                            done_ecx_reg <= ex_ecx_reg;
                        end else if (mode_reg == 2'b01) begin
                            ex_ecx_reg  <= next_dec;
                            ex_last_reg <= is_zero(next_dec, addr32_reg);
                        end else begin
                            state_reg    <= WAIT_FLAG;
                            ex_valid_reg <= 1'b0;
                        end
                    end
                end
                WAIT_FLAG: begin
                    if (bus.fb_valid) begin
                        if (terminate) begin
                            state_reg    <= IDLE;
                            seq_done_reg <= 1'b1;
                            done_ecx_reg <= count_reg;
                        end else begin
                            state_reg    <= ISSUE;
                            ex_valid_reg <= 1'b1;
                            ex_ecx_reg   <= count_dec;
                            ex_last_reg  <= is_zero(count_dec, addr32_reg);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Reset and flush take effect on the outputs in the same cycle they are asserted.
    assign issue_valid  = reset & ~flush & ex_valid_reg;
    assign bus.up_ready = reset & ~flush & (state_reg == IDLE);
    assign bus.ex_valid = issue_valid;
    assign bus.ex_last  = issue_valid & ex_last_reg;
    assign bus.ex_ecx   = reset ? ex_ecx_reg : '0;
    assign bus.seq_done = reset & seq_done_reg;
    assign bus.done_ecx = reset ? done_ecx_reg : '0;
    assign bus.busy     = reset & (state_reg != IDLE);
endmodule

// File: tb/tb_rep_sequencer.sv
// Bench for rep_sequencer: a sequence-level predictor feeds expected iterations and
// final counts to a per-cycle comparator, alongside directed literal checks.
module tb_rep_sequencer;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] ecx;
        logic         last;
    } iter_t;

    logic clk;
    logic reset;
    logic flush;

    rep_sequencer_if #(.ECX_WIDTH(W)) bus ();

    rep_sequencer #(.ECX_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    iter_t        exp_iter[$];
    logic [W-1:0] exp_done[$];
    iter_t        model_q[$];
    logic [W-1:0] model_done;
    logic [W-1:0] obs_ecx[$];
    int           obs_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sequence-level prediction: the list of counts each iteration must carry and the final count.
    function automatic void predict(input logic [1:0] mode, input logic a32,
                                    input logic [W-1:0] ecx, input logic [7:0] zf_bits);
        longint       n;
        logic [W-1:0] upper;
        iter_t        e;
        logic         zf;
        model_q.delete();
        upper      = a32 ? '0 : (ecx & 32'hFFFF_0000);
        n          = a32 ? longint'(ecx) : longint'(ecx & 32'h0000_FFFF);
        model_done = ecx;
        if (mode == 2'b00) begin
            e.ecx  = ecx;
            e.last = 1'b1;
            model_q.push_back(e);
            return;
        end
        for (longint i = 1; i <= n; i++) begin
            e.ecx      = upper | W'(n - i);
            e.last     = (n - i) == 0;
            model_q.push_back(e);
            model_done = e.ecx;
            if (e.last) break;
            if (mode != 2'b01) begin
                zf = zf_bits[int'(i - 1)];
                if ((mode == 2'b10 && !zf) || (mode == 2'b11 && zf)) break;
            end
        end
    endfunction

    // Comparator: every handshake and every done pulse is matched against the prediction.
    iter_t        cmp_e;
    logic [W-1:0] cmp_d;
    always @(negedge clk) begin
        if (bus.ex_valid && bus.ex_ready) begin
            if (exp_iter.size() == 0) begin
                chk("unexpected_iteration", {32'h0, bus.ex_ecx}, 64'hDEAD);
            end else begin
                cmp_e = exp_iter.pop_front();
                chk("iter_ecx", bus.ex_ecx, cmp_e.ecx);
                chk("iter_last", bus.ex_last, cmp_e.last);
            end
        end
        if (bus.seq_done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", {32'h0, bus.done_ecx}, 64'hDEAD);
            end else begin
                cmp_d = exp_done.pop_front();
                chk("done_ecx", bus.done_ecx, cmp_d);
            end
        end
    end

    // Runs one instruction from acceptance to seq_done; entered and left at posedge+1.
    task automatic run_seq(input logic [1:0] mode, input logic a32, input logic [W-1:0] ecx,
                           input logic [7:0] zf_bits, input int stall_iter, input int stall_cycles,
                           input int fb_delay, output int iters, output logic [W-1:0] done_val,
                           output int stalls, output logic [W-1:0] held);
        int   stall_left;
        int   fb_cd;
        logic waiting;
        logic seen;
        logic hs;
        logic lastv;
        predict(mode, a32, ecx, zf_bits);
        foreach (model_q[i]) exp_iter.push_back(model_q[i]);
        exp_done.push_back(model_done);
        obs_ecx.delete();
        obs_cyc.delete();
        bus.up_valid    = 1'b1;
        bus.up_rep_mode = mode;
        bus.up_addr32   = a32;
        bus.up_ecx      = ecx;
        bus.ex_ready    = !(stall_iter == 1 && stall_cycles > 0);
        @(negedge clk);
        chk("accept_ready", bus.up_ready, 1);
        @(posedge clk); #1;
        bus.up_valid = 1'b0;
        iters = 0; stalls = 0; held = '0; done_val = '0;
        stall_left = stall_cycles; fb_cd = 0; waiting = 1'b0; seen = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            @(negedge clk);
            hs    = bus.ex_valid & bus.ex_ready;
            lastv = bus.ex_last;
            if (hs) begin
                obs_ecx.push_back(bus.ex_ecx);
                obs_cyc.push_back(cyc);
            end
            if (waiting) chk("no_issue_in_wait", bus.ex_valid, 0);
            if (bus.ex_valid && !bus.ex_ready) begin
                if (stalls == 0) held = bus.ex_ecx;
                else chk("stall_hold", bus.ex_ecx, held);
                stalls++;
                stall_left--;
            end
            if (bus.seq_done) begin
                seen     = 1'b1;
                done_val = bus.done_ecx;
            end
            @(posedge clk); #1;
            bus.fb_valid = 1'b0;
            if (hs) begin
                iters++;
                if (mode[1] && !lastv) begin
                    waiting = 1'b1;
                    fb_cd   = fb_delay;
                end
            end
            if (waiting) begin
                if (fb_cd == 0) begin
                    bus.fb_valid = 1'b1;
                    bus.fb_zf    = zf_bits[iters - 1];
                    waiting      = 1'b0;
                end else begin
                    fb_cd--;
                end
            end
            bus.ex_ready = !(iters == stall_iter - 1 && stall_left > 0);
        end
        if (!seen) chk("seq_done_timeout", 0, 1);
        $display("seq mode=%0d a32=%0d ecx=0x%08h iters=%0d done=0x%08h stalls=%0d",
                 mode, a32, ecx, iters, done_val, stalls);
    endtask

    int           it;
    int           st;
    logic [W-1:0] dv;
    logic [W-1:0] hd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0;
        bus.up_valid = 1'b0; bus.up_rep_mode = 2'b00; bus.up_addr32 = 1'b0; bus.up_ecx = '0;
        bus.ex_ready = 1'b0; bus.fb_valid = 1'b0; bus.fb_zf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_up_ready", bus.up_ready, 0);
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_ex_last", bus.ex_last, 0);
        chk("rst_seq_done", bus.seq_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ex_ecx", bus.ex_ecx, 0);
        chk("rst_done_ecx", bus.done_ecx, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_up_ready", bus.up_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        @(posedge clk); #1;

        // REP, 32-bit, count 3, execute always ready
        run_seq(2'b01, 1'b1, 32'd3, 8'h00, 0, 0, 0, it, dv, st, hd);
        chk("m_pin_size", model_q.size(), 3);
        chk("m_pin_ecx0", model_q[0].ecx, 2);
        chk("m_pin_last2", model_q[2].last, 1);
        chk("m_pin_done", model_done, 0);
        chk("r39_iters", it, 3);
        chk("r39_ecx0", obs_ecx[0], 2);
        chk("r39_ecx2", obs_ecx[2], 0);
        chk("r39_back_to_back", obs_cyc[2] - obs_cyc[0], 2);
        chk("r39_done", dv, 0);

        // REPE, count 5, ZF 1,1,0, flags arrive two cycles late
        run_seq(2'b10, 1'b1, 32'd5, 8'b0000_0011, 0, 0, 2, it, dv, st, hd);
        chk("m_pin40_size", model_q.size(), 3);
        chk("r40_iters", it, 3);
        chk("r40_done", dv, 2);

        // 16-bit count: upper half preserved, then zero count
        run_seq(2'b01, 1'b0, 32'hABCD_0001, 8'h00, 0, 0, 0, it, dv, st, hd);
        chk("r41_iters", it, 1);
        chk("r41_ecx", obs_ecx[0], 32'hABCD_0000);
        run_seq(2'b01, 1'b0, 32'hABCD_0000, 8'h00, 0, 0, 0, it, dv, st, hd);
        chk("r41_zero_iters", it, 0);
        chk("r41_zero_done", dv, 32'hABCD_0000);

        // REPNE, count 4, iteration 2 stalled three cycles, ZF 0 then 1
        run_seq(2'b11, 1'b1, 32'd4, 8'b0000_0010, 2, 3, 0, it, dv, st, hd);
        chk("r42_stalls", st, 3);
        chk("r42_held", hd, 2);
        chk("r42_done", dv, 2);

        // No prefix: single iteration, count unchanged (including zero)
        run_seq(2'b00, 1'b1, 32'd7, 8'h00, 0, 0, 0, it, dv, st, hd);
        chk("none_iters", it, 1);
        chk("none_done", dv, 7);
        run_seq(2'b00, 1'b0, 32'd0, 8'h00, 0, 0, 0, it, dv, st, hd);
        chk("none_zero_iters", it, 1);

        // Wrap confinement, maximum counts, 32-bit zero count
        run_seq(2'b01, 1'b0, 32'h0001_0002, 8'h00, 0, 0, 1, it, dv, st, hd);
        chk("wrap_done", dv, 32'h0001_0000);
        run_seq(2'b10, 1'b0, 32'h5555_FFFF, 8'h00, 0, 0, 1, it, dv, st, hd);
        chk("max16_done", dv, 32'h5555_FFFE);
        run_seq(2'b11, 1'b1, 32'hFFFF_FFFF, 8'h01, 0, 0, 1, it, dv, st, hd);
        chk("max32_done", dv, 32'hFFFF_FFFE);
        run_seq(2'b10, 1'b1, 32'd0, 8'h00, 0, 0, 0, it, dv, st, hd);
        chk("zero32_iters", it, 0);

        // Flush in ISSUE coincident with ex_ready
        bus.up_valid = 1'b1; bus.up_rep_mode = 2'b01; bus.up_addr32 = 1'b1; bus.up_ecx = 32'd10;
        bus.ex_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.up_valid = 1'b0;
        @(negedge clk);
        chk("r43_issue_valid", bus.ex_valid, 1);
        chk("r43_issue_ecx", bus.ex_ecx, 9);
        chk("r43_busy", bus.busy, 1);
        @(posedge clk); #1;
        flush = 1'b1; bus.ex_ready = 1'b1;
        @(negedge clk);
        chk("r43_flush_ex_valid", bus.ex_valid, 0);
        chk("r43_flush_up_ready", bus.up_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; bus.ex_ready = 1'b0;
        @(negedge clk);
        chk("r43_idle_up_ready", bus.up_ready, 1);
        chk("r43_idle_busy", bus.busy, 0);
        chk("r43_no_done", bus.seq_done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r43_no_done_late", bus.seq_done, 0);
        $display("seq flush mode=1 ecx=0x0000000a aborted");
        @(posedge clk); #1;

        // Reset while waiting for flags; later feedback must be ignored
        begin
            iter_t e;
            e.ecx = 32'd4; e.last = 1'b0;
            exp_iter.push_back(e);
        end
        bus.up_valid = 1'b1; bus.up_rep_mode = 2'b10; bus.up_addr32 = 1'b1; bus.up_ecx = 32'd5;
        bus.ex_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.up_valid = 1'b0;
        @(negedge clk);
        chk("r44_issue", bus.ex_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r44_wait_busy", bus.busy, 1);
        chk("r44_wait_ex_valid", bus.ex_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("r44_rst_up_ready", bus.up_ready, 0);
        chk("r44_rst_ex_valid", bus.ex_valid, 0);
        chk("r44_rst_ex_last", bus.ex_last, 0);
        chk("r44_rst_seq_done", bus.seq_done, 0);
        chk("r44_rst_busy", bus.busy, 0);
        chk("r44_rst_ex_ecx", bus.ex_ecx, 0);
        chk("r44_rst_done_ecx", bus.done_ecx, 0);
        @(posedge clk); #1;
        reset = 1'b1; bus.fb_valid = 1'b1; bus.fb_zf = 1'b1;
        @(negedge clk);
        chk("r44_idle_up_ready", bus.up_ready, 1);
        chk("r44_idle_busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.fb_valid = 1'b0;
        @(negedge clk);
        chk("r44_fb_ignored_valid", bus.ex_valid, 0);
        chk("r44_fb_ignored_busy", bus.busy, 0);
        chk("r44_no_done", bus.seq_done, 0);
        $display("seq reset-abort mode=2 ecx=0x00000005 aborted");
        @(posedge clk); #1;

        chk("exp_iter_drained", exp_iter.size(), 0);
        chk("exp_done_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
